// File: rtl/toggle_activity_counter.sv
// Per-net toggle counter over a programmable window, results streamed over valid/ready.
// Optional WEIGHTED_POWER_EN adds a weighted activity sum on the last beat.
module toggle_activity_counter #(
  parameter int N_SIG = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int WGT_W = 8,
  localparam int IDX_W = $clog2(N_SIG),
  localparam int WS_W = CNT_W + WGT_W + IDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [N_SIG-1:0]       sig_in,
  input  logic [N_SIG*WGT_W-1:0] weight_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_last,
  output logic [WS_W-1:0]        out_wsum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] r_wcnt;
  logic [N_SIG-1:0] r_prev;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt [N_SIG];

  logic w_last_idx;
  logic w_win_done;

  assign w_last_idx = (r_idx == IDX_W'(N_SIG - 1));
  assign w_win_done = (r_wcnt == r_win);

`ifdef WEIGHTED_POWER_EN
  logic [WGT_W-1:0] r_wgt [N_SIG];
  logic [WS_W-1:0]  r_acc;
  logic [WS_W-1:0]  w_prod;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_ARM;
      S_ARM:   w_next = S_COUNT;
      S_COUNT: if (w_win_done) w_next = S_DRAIN;
      S_DRAIN: if (out_ready && w_last_idx) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win  <= '0;
      r_wcnt <= '0;
      r_prev <= '0;
      r_idx  <= '0;
      for (int i = 0; i < N_SIG; i++) r_cnt[i] <= '0;
`ifdef WEIGHTED_POWER_EN
      r_acc <= '0;
      for (int i = 0; i < N_SIG; i++) r_wgt[i] <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_win  <= (win_len == '0) ? WIN_W'(1) : win_len;
            r_wcnt <= WIN_W'(1);
            r_idx  <= '0;
            for (int i = 0; i < N_SIG; i++) r_cnt[i] <= '0;
`ifdef WEIGHTED_POWER_EN
            r_acc <= '0;
            for (int i = 0; i < N_SIG; i++)
              r_wgt[i] <= weight_in[i*WGT_W +: WGT_W];
`endif
          end
        end
        S_ARM: r_prev <= sig_in;
        S_COUNT: begin
          r_prev <= sig_in;
          r_wcnt <= r_wcnt + WIN_W'(1);
          // counters stick at all-ones
          for (int i = 0; i < N_SIG; i++)
            if (r_cnt[i] != '1)
              r_cnt[i] <= r_cnt[i] + CNT_W'(sig_in[i] ^ r_prev[i]);
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
`ifdef WEIGHTED_POWER_EN
            r_acc <= r_acc + w_prod;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DRAIN);
  assign out_idx   = r_idx;
  assign out_count = out_valid ? r_cnt[r_idx] : '0;
  assign out_last  = out_valid && w_last_idx;

`ifdef WEIGHTED_POWER_EN
  assign w_prod   = WS_W'(out_count) * WS_W'(r_wgt[r_idx]);
  assign out_wsum = out_last ? (r_acc + w_prod) : '0;
`else
  logic w_unused;
  assign w_unused = ^weight_in;
  assign out_wsum = '0;
`endif

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Directed bench for toggle_activity_counter (N_SIG=2, CNT_W=3).
// Expected weighted sum depends on WEIGHTED_POWER_EN.
module tb_toggle_activity_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] win_len;
  logic [1:0]  sig_in;
  logic [15:0] weight_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_idx;
  logic [2:0]  out_count;
  logic        out_last;
  logic [11:0] out_wsum;

  int checks = 0;
  int failures = 0;
  int nb;
  int b_idx [4];
  int b_cnt [4];
  int b_last [4];
  int b_wsum [4];

`ifdef WEIGHTED_POWER_EN
  localparam int EXP_WSUM = 22;
`else
  localparam int EXP_WSUM = 0;
`endif

  always #5 clk = ~clk;

  toggle_activity_counter #(
    .N_SIG(2), .CNT_W(3), .WIN_W(16), .WGT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .win_len(win_len), .sig_in(sig_in),
    .weight_in(weight_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_count(out_count),
    .out_last(out_last), .out_wsum(out_wsum)
  );

  // mode 0: net0 toggles every COUNT cycle, net1 held 1
  // mode 1: as mode 0, plus net1 toggles on the first two
  task automatic run_window(input logic [15:0] wl,
                            input int mode,
                            input int pulse_k,
                            input logic [15:0] wt,
                            output bit busy_ok);
    int n;
    n = (wl == 0) ? 1 : int'(wl);
    busy_ok = 1'b1;
    weight_in = wt;
    win_len = wl;
    sig_in = 2'b10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    weight_in = 16'hffff;
    win_len = 16'd1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    @(posedge clk); #1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= n; k++) begin
      sig_in[0] = ~sig_in[0];
      if (mode == 1 && k <= 2) sig_in[1] = ~sig_in[1];
      start = (k == pulse_k);
      @(posedge clk); #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic drain(input bit start_on_last);
    nb = 0;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      if (out_valid && out_ready) begin
        b_idx[nb]  = int'(out_idx);
        b_cnt[nb]  = int'(out_count);
        b_last[nb] = int'(out_last);
        b_wsum[nb] = int'(out_wsum);
        if (start_on_last && out_last) begin
          start = 1'b1;
          win_len = 16'd3;
        end
        nb++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    sig_in = 2'b00;
    win_len = 16'd0;
    weight_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got %0b want 0", busy);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got %0b want 0", out_valid);
    end
    checks++;
    if (out_idx !== 1'b0) begin
      failures++; $display("FAIL rst_idx got %0d want 0", out_idx);
    end
    checks++;
    if (out_last !== 1'b0) begin
      failures++; $display("FAIL rst_last got %0b want 0", out_last);
    end
    checks++;
    if (out_count !== 3'd0) begin
      failures++; $display("FAIL rst_count got %0d want 0", out_count);
    end
    checks++;
    if (out_wsum !== 12'd0) begin
      failures++; $display("FAIL rst_wsum got %0d want 0", out_wsum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit bok;
    run_window(16'd4, 0, 0, 16'h0503, bok);
    checks++;
    if (!bok) begin
      failures++; $display("FAIL basic_busy got 0 want 1");
    end
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_count !== 3'd4
        || out_last !== 1'b0) begin
      failures++;
      $display("FAIL basic_beat0 got v=%0b i=%0d c=%0d l=%0b want 1 0 4 0",
               out_valid, out_idx, out_count, out_last);
    end
    out_ready = 1'b1;
    drain(1'b0);
    checks++;
    if (nb != 2) begin
      failures++; $display("FAIL basic_nbeats got %0d want 2", nb);
    end
    checks++;
    if (b_idx[0] != 0 || b_cnt[0] != 4 || b_last[0] != 0) begin
      failures++;
      $display("FAIL basic_b0 got %0d,%0d,%0d want 0,4,0",
               b_idx[0], b_cnt[0], b_last[0]);
    end
    checks++;
    if (b_idx[1] != 1 || b_cnt[1] != 0 || b_last[1] != 1) begin
      failures++;
      $display("FAIL basic_b1 got %0d,%0d,%0d want 1,0,1",
               b_idx[1], b_cnt[1], b_last[1]);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end got v=%0b b=%0b want 0 0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    bit bok;
    run_window(16'd10, 0, 0, 16'h0503, bok);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 3'd7) begin
      failures++;
      $display("FAIL sat_beat0 got v=%0b c=%0d want 1 7", out_valid, out_count);
    end
    out_ready = 1'b1;
    drain(1'b0);
    checks++;
    if (nb != 2 || b_cnt[0] != 7 || b_cnt[1] != 0) begin
      failures++;
      $display("FAIL sat_counts got n=%0d %0d,%0d want 2 7,0",
               nb, b_cnt[0], b_cnt[1]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_win_zero();
    bit bok;
    run_window(16'd0, 0, 0, 16'h0503, bok);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL win0_valid got %0b want 1", out_valid);
    end
    out_ready = 1'b1;
    drain(1'b0);
    checks++;
    if (nb != 2 || b_cnt[0] != 1 || b_cnt[1] != 0) begin
      failures++;
      $display("FAIL win0_counts got n=%0d %0d,%0d want 2 1,0",
               nb, b_cnt[0], b_cnt[1]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit bok;
    out_ready = 1'b0;
    run_window(16'd4, 0, 0, 16'h0503, bok);
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_count !== 3'd4) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%0b i=%0d c=%0d want 1 0 4",
                 h, out_valid, out_idx, out_count);
      end
      sig_in = ~sig_in;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain(1'b0);
    checks++;
    if (nb != 2 || b_idx[0] != 0 || b_cnt[0] != 4
        || b_idx[1] != 1 || b_cnt[1] != 0) begin
      failures++;
      $display("FAIL bp_beats got n=%0d (%0d,%0d) (%0d,%0d) want 2 (0,4) (1,0)",
               nb, b_idx[0], b_cnt[0], b_idx[1], b_cnt[1]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit bok;
    out_ready = 1'b0;
    run_window(16'd4, 0, 2, 16'h0503, bok);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 3'd4) begin
      failures++;
      $display("FAIL ign_count got v=%0b c=%0d want 1 4", out_valid, out_count);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 1'b0) begin
      failures++;
      $display("FAIL ign_drain got v=%0b i=%0d want 1 0", out_valid, out_idx);
    end
    out_ready = 1'b1;
    drain(1'b1);
    checks++;
    if (nb != 2 || b_cnt[0] != 4 || b_cnt[1] != 0) begin
      failures++;
      $display("FAIL ign_beats got n=%0d %0d,%0d want 2 4,0",
               nb, b_cnt[0], b_cnt[1]);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ign_last_start got b=%0b v=%0b want 0 0", busy, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL ign_idle got %0b want 0", busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bok;
    sig_in = 2'b10;
    win_len = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      sig_in = ~sig_in;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_count !== 3'd0) begin
      failures++;
      $display("FAIL rmid_abort got b=%0b v=%0b c=%0d want 0 0 0",
               busy, out_valid, out_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_window(16'd4, 0, 0, 16'h0503, bok);
    out_ready = 1'b1;
    drain(1'b0);
    checks++;
    if (nb != 2 || b_cnt[0] != 4 || b_cnt[1] != 0) begin
      failures++;
      $display("FAIL rmid_fresh got n=%0d %0d,%0d want 2 4,0",
               nb, b_cnt[0], b_cnt[1]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_weighted();
    bit bok;
    run_window(16'd4, 1, 0, 16'h0503, bok);
    out_ready = 1'b1;
    drain(1'b0);
    checks++;
    if (nb != 2 || b_cnt[0] != 4 || b_cnt[1] != 2) begin
      failures++;
      $display("FAIL wsum_counts got n=%0d %0d,%0d want 2 4,2",
               nb, b_cnt[0], b_cnt[1]);
    end
    checks++;
    if (b_wsum[0] != 0) begin
      failures++; $display("FAIL wsum_b0 got %0d want 0", b_wsum[0]);
    end
    checks++;
    if (b_wsum[1] != EXP_WSUM) begin
      failures++;
      $display("FAIL wsum_last got %0d want %0d", b_wsum[1], EXP_WSUM);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_win_zero();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_weighted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
